// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency sweep controller: default widths,
// sweep mode encodings and the controller state type.
package dds_pkg;

    localparam int FREQ_W  = 20;
    localparam int DWELL_W = 16;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_REPEAT = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep controller for a DDS: steps a registered frequency word from
// f_start to f_stop once per dwell of sample ticks, in single, repeat or triangle mode.
module dds_sweep_ctrl #(
    parameter int FREQ_W  = dds_pkg::FREQ_W,
    parameter int DWELL_W = dds_pkg::DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               sample_tick,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_stop,
    input  logic [FREQ_W-1:0]  f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [1:0]         mode,
    output logic [FREQ_W-1:0]  freq,
    output logic               busy,
    output logic               done,
    output logic               step_tick
);
    import dds_pkg::*;

    sweep_state_e       state_q, state_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic [FREQ_W-1:0]  f_start_q, f_start_d;
    logic [FREQ_W-1:0]  f_stop_q, f_stop_d;
    logic [FREQ_W-1:0]  f_step_q, f_step_d;
    logic [DWELL_W-1:0] dwell_eff_q, dwell_eff_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               degen_q, degen_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               step_tick_q, step_tick_d;

    logic [FREQ_W:0]    sum_s;
    logic [FREQ_W-1:0]  diff_s;
    logic [FREQ_W-1:0]  up_next_s;
    logic [FREQ_W-1:0]  down_next_s;
    logic               dwell_end_s;

    // Clamped neighbours of the current frequency; sum is one bit wider so it cannot wrap.
    always_comb begin
        sum_s       = {1'b0, freq_q} + {1'b0, f_step_q};
        diff_s      = freq_q - f_start_q;
        up_next_s   = (sum_s >= {1'b0, f_stop_q}) ? f_stop_q : sum_s[FREQ_W-1:0];
        down_next_s = (f_step_q >= diff_s) ? f_start_q : (freq_q - f_step_q);
        dwell_end_s = sample_tick && (cnt_q == (dwell_eff_q - {{(DWELL_W-1){1'b0}}, 1'b1}));
    end

    // Next-state, datapath and output pulse logic.
    always_comb begin
        state_d     = state_q;
        freq_d      = freq_q;
        f_start_d   = f_start_q;
        f_stop_d    = f_stop_q;
        f_step_d    = f_step_q;
        dwell_eff_d = dwell_eff_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        degen_d     = degen_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        step_tick_d = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = {DWELL_W{1'b0}};
        end else if (start) begin
            f_start_d   = f_start;
            f_stop_d    = f_stop;
            f_step_d    = f_step;
            dwell_eff_d = (dwell == {DWELL_W{1'b0}}) ? {{(DWELL_W-1){1'b0}}, 1'b1} : dwell;
            mode_d      = mode;
            degen_d     = (f_step == {FREQ_W{1'b0}}) || (f_start >= f_stop);
            freq_d      = f_start;
            state_d     = ST_UP;
            busy_d      = 1'b1;
            cnt_d       = {DWELL_W{1'b0}};
        end else begin
            case (state_q)
                ST_UP, ST_DOWN: begin
                    if (sample_tick) begin
                        if (dwell_end_s) begin
                            cnt_d = {DWELL_W{1'b0}};
                            if (degen_q) begin
                                // Degenerate ramp: parked on f_start, only single mode ever ends.
                                if ((mode_q != MODE_REPEAT) && (mode_q != MODE_TRI)) begin
                                    state_d = ST_IDLE;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                end else begin
                                    state_d = state_q;
                                end
                            end else if (state_q == ST_UP) begin
                                if (freq_q == f_stop_q) begin
                                    case (mode_q)
                                        MODE_REPEAT: begin
                                            freq_d      = f_start_q;
                                            step_tick_d = 1'b1;
                                        end
                                        MODE_TRI: begin
                                            state_d     = ST_DOWN;
                                            freq_d      = down_next_s;
                                            step_tick_d = 1'b1;
                                        end
                                        default: begin
                                            state_d = ST_IDLE;
                                            busy_d  = 1'b0;
                                            done_d  = 1'b1;
                                        end
                                    endcase
                                end else begin
                                    freq_d      = up_next_s;
                                    step_tick_d = 1'b1;
                                end
                            end else begin
                                if (freq_q == f_start_q) begin
                                    state_d = ST_UP;
                                    freq_d  = up_next_s;
                                end else begin
                                    freq_d  = down_next_s;
                                end
                                step_tick_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            freq_q      <= {FREQ_W{1'b0}};
            f_start_q   <= {FREQ_W{1'b0}};
            f_stop_q    <= {FREQ_W{1'b0}};
            f_step_q    <= {FREQ_W{1'b0}};
            dwell_eff_q <= {{(DWELL_W-1){1'b0}}, 1'b1};
            cnt_q       <= {DWELL_W{1'b0}};
            mode_q      <= MODE_SINGLE;
            degen_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            step_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            freq_q      <= freq_d;
            f_start_q   <= f_start_d;
            f_stop_q    <= f_stop_d;
            f_step_q    <= f_step_d;
            dwell_eff_q <= dwell_eff_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            degen_q     <= degen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            step_tick_q <= step_tick_d;
        end
    end

    assign freq      = freq_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step_tick = step_tick_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl with hand-computed expectations.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        sample_tick = 1'b0;
    logic [19:0] f_start = 20'd0;
    logic [19:0] f_stop = 20'd0;
    logic [19:0] f_step = 20'd0;
    logic [15:0] dwell = 16'd0;
    logic [1:0]  mode = 2'd0;
    logic [19:0] freq;
    logic        busy;
    logic        done;
    logic        step_tick;

    int total = 0;
    int bad   = 0;

    dds_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_tick(sample_tick),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell), .mode(mode),
        .freq(freq), .busy(busy), .done(done), .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the full output set in one call.
    task automatic check_all(input string tag, input logic [19:0] ef, input logic eb,
                             input logic ed, input logic es);
        check({tag, ".freq"}, {12'd0, freq}, {12'd0, ef});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
        check({tag, ".done"}, {31'd0, done}, {31'd0, ed});
        check({tag, ".step"}, {31'd0, step_tick}, {31'd0, es});
    endtask

    task automatic do_start(input logic [1:0] m, input logic [19:0] fs, input logic [19:0] fe,
                            input logic [19:0] st, input logic [15:0] dw);
        mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw;
        start = 1'b1;
        cyc();
        start = 1'b0;
        f_start = 20'd7; f_stop = 20'd9; f_step = 20'd1; dwell = 16'd5; mode = 2'd1;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        check_all("reset", 20'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc();

        // Single sweep, dwell 2
        do_start(2'd0, 20'd100, 20'd130, 20'd10, 16'd2);
        check_all("s.start", 20'd100, 1'b1, 1'b0, 1'b0);
        tick(); check_all("s.t1", 20'd100, 1'b1, 1'b0, 1'b0);
        cyc();  check_all("s.gap", 20'd100, 1'b1, 1'b0, 1'b0);
        tick(); check_all("s.t2", 20'd110, 1'b1, 1'b0, 1'b1);
        tick(); tick(); check_all("s.t4", 20'd120, 1'b1, 1'b0, 1'b1);
        tick(); tick(); check_all("s.t6", 20'd130, 1'b1, 1'b0, 1'b1);
        tick(); check_all("s.t7", 20'd130, 1'b1, 1'b0, 1'b0);
        tick(); check_all("s.end", 20'd130, 1'b0, 1'b1, 1'b0);
        cyc();  check_all("s.after", 20'd130, 1'b0, 1'b0, 1'b0);
        tick(); check_all("s.idle_tick", 20'd130, 1'b0, 1'b0, 1'b0);

        // Clamped final step
        do_start(2'd3, 20'd100, 20'd125, 20'd10, 16'd1);
        check_all("c.start", 20'd100, 1'b1, 1'b0, 1'b0);
        tick(); check_all("c.t1", 20'd110, 1'b1, 1'b0, 1'b1);
        tick(); check_all("c.t2", 20'd120, 1'b1, 1'b0, 1'b1);
        tick(); check_all("c.t3", 20'd125, 1'b1, 1'b0, 1'b1);
        tick(); check_all("c.end", 20'd125, 1'b0, 1'b1, 1'b0);

        // Repeat mode near the top of the range
        do_start(2'd1, 20'hFFFF0, 20'hFFFFF, 20'd8, 16'd1);
        check_all("o.start", 20'hFFFF0, 1'b1, 1'b0, 1'b0);
        tick(); check_all("o.t1", 20'hFFFF8, 1'b1, 1'b0, 1'b1);
        tick(); check_all("o.t2", 20'hFFFFF, 1'b1, 1'b0, 1'b1);
        tick(); check_all("o.wrap", 20'hFFFF0, 1'b1, 1'b0, 1'b1);
        tick(); check_all("o.t4", 20'hFFFF8, 1'b1, 1'b0, 1'b1);

        // Triangle with dwell 0 (acts as 1)
        do_start(2'd2, 20'd0, 20'd20, 20'd10, 16'd0);
        check_all("tri.start", 20'd0, 1'b1, 1'b0, 1'b0);
        tick(); check_all("tri.t1", 20'd10, 1'b1, 1'b0, 1'b1);
        tick(); check_all("tri.t2", 20'd20, 1'b1, 1'b0, 1'b1);
        tick(); check_all("tri.t3", 20'd10, 1'b1, 1'b0, 1'b1);
        tick(); check_all("tri.t4", 20'd0, 1'b1, 1'b0, 1'b1);
        cyc();  check_all("tri.gap", 20'd0, 1'b1, 1'b0, 1'b0);
        tick(); check_all("tri.t5", 20'd10, 1'b1, 1'b0, 1'b1);

        // Restart while busy clears the partial dwell count
        do_start(2'd0, 20'd100, 20'd130, 20'd10, 16'd2);
        tick();
        do_start(2'd0, 20'd200, 20'd300, 20'd5, 16'd2);
        check_all("r.start", 20'd200, 1'b1, 1'b0, 1'b0);
        tick(); check_all("r.t1", 20'd200, 1'b1, 1'b0, 1'b0);
        tick(); check_all("r.t2", 20'd205, 1'b1, 1'b0, 1'b1);

        // Abort with stop, then start+stop together
        do_start(2'd0, 20'd100, 20'd200, 20'd10, 16'd1);
        tick(); check_all("a.t1", 20'd110, 1'b1, 1'b0, 1'b1);
        stop = 1'b1; cyc(); stop = 1'b0;
        check_all("a.stop", 20'd110, 1'b0, 1'b0, 1'b0);
        tick(); check_all("a.idle", 20'd110, 1'b0, 1'b0, 1'b0);
        mode = 2'd0; f_start = 20'd50; f_stop = 20'd90; f_step = 20'd1; dwell = 16'd1;
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        check_all("a.both", 20'd110, 1'b0, 1'b0, 1'b0);

        // Reset mid-sweep, and reset overriding start
        do_start(2'd1, 20'd100, 20'd200, 20'd10, 16'd1);
        tick(); check_all("x.t1", 20'd110, 1'b1, 1'b0, 1'b1);
        rst = 1'b1; cyc();
        check_all("x.rst", 20'd0, 1'b0, 1'b0, 1'b0);
        mode = 2'd0; f_start = 20'd40; f_stop = 20'd90; f_step = 20'd1; dwell = 16'd1;
        start = 1'b1; cyc(); start = 1'b0; rst = 1'b0;
        check_all("x.rst_start", 20'd0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Degenerate: zero step in single mode finishes after one dwell
        do_start(2'd0, 20'd50, 20'd90, 20'd0, 16'd3);
        tick(); tick(); check_all("d.t2", 20'd50, 1'b1, 1'b0, 1'b0);
        tick(); check_all("d.end", 20'd50, 1'b0, 1'b1, 1'b0);

        // Degenerate: zero step in triangle mode holds until stop
        do_start(2'd2, 20'd50, 20'd90, 20'd0, 16'd1);
        tick(); check_all("dt.t1", 20'd50, 1'b1, 1'b0, 1'b0);
        tick(); check_all("dt.t2", 20'd50, 1'b1, 1'b0, 1'b0);
        tick(); check_all("dt.t3", 20'd50, 1'b1, 1'b0, 1'b0);
        stop = 1'b1; cyc(); stop = 1'b0;
        check_all("dt.stop", 20'd50, 1'b0, 1'b0, 1'b0);

        // Degenerate: f_start above f_stop in repeat mode holds
        do_start(2'd1, 20'd80, 20'd60, 20'd5, 16'd1);
        tick(); check_all("dr.t1", 20'd80, 1'b1, 1'b0, 1'b0);
        tick(); check_all("dr.t2", 20'd80, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
